// File: rtl/encoder_8_3_queued.sv
// Sequential 8-to-3 request encoder: captures requests on D0..D7, holds them
// pending, and offers one index at a time as A2..A0 on a V/RDY handshake.
// ROUND_ROBIN=0 selects the highest pending index; ROUND_ROBIN=1 rotates
// ascending from one past the last accepted index.
module encoder_8_3_queued #(
    parameter int unsigned ROUND_ROBIN = 0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    input  logic RDY,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic V,
    output logic MULTI,
    output logic OVF
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] req;
    logic [7:0] served;
    logic [2:0] code_q, code_d;
    logic [2:0] last_q, last_d;
    logic       ovf_q, ovf_d;

    // Winner among pending bits. Round robin scans last+8 down to last+1 so
    // the final assignment is the nearest index after last (last itself is
    // lowest priority, reached through the 3-bit wrap of last+8).
    function automatic logic [2:0] select_idx(input logic [7:0] p, input logic [2:0] last);
        logic [2:0] sel;
        logic [2:0] idx;
        sel = '0;
        idx = '0;
        if (ROUND_ROBIN != 0) begin
            for (int unsigned k = 8; k >= 1; k--) begin
                idx = last + 3'(k);
                if (p[idx]) sel = idx;
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (p[i]) sel = 3'(i);
            end
        end
        return sel;
    endfunction

    // Pending-mask update: clear the accepted index, merge new requests, flag merges.
    always_comb begin
        req    = {D7, D6, D5, D4, D3, D2, D1, D0};
        served = '0;
        if (state_q == OFFER && RDY) served[code_q] = 1'b1;
        pend_d = (pend_q & ~served) | req;
        ovf_d  = |(req & pend_q & ~served);
    end

    // Handshake FSM: load a new code when idle or on acceptance, hold under backpressure.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pend_d != '0) begin
                    code_d  = select_idx(pend_d, last_q);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (RDY) begin
                    last_d = code_q;
                    if (pend_d != '0) begin
                        code_d = select_idx(pend_d, code_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pend_q  <= '0;
            code_q  <= '0;
            last_q  <= 3'd7;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign {A2, A1, A0} = code_q;
    assign V            = (state_q == OFFER);
    assign OVF          = ovf_q;
    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign MULTI        = |(pend_q & (pend_q - 8'd1));

endmodule

// File: tb/tb_encoder_8_3_queued.sv
module tb_encoder_8_3_queued;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       rdy;

    logic a0_f, a1_f, a2_f, v_f, multi_f, ovf_f;
    logic a0_r, a1_r, a2_r, v_r, multi_r, ovf_r;

    encoder_8_3_queued #(.ROUND_ROBIN(0)) u_fixed (
        .CLK(clk), .RST_N(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .RDY(rdy),
        .A0(a0_f), .A1(a1_f), .A2(a2_f),
        .V(v_f), .MULTI(multi_f), .OVF(ovf_f)
    );

    encoder_8_3_queued #(.ROUND_ROBIN(1)) u_rr (
        .CLK(clk), .RST_N(rst_n),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .RDY(rdy),
        .A0(a0_r), .A1(a1_r), .A2(a2_r),
        .V(v_r), .MULTI(multi_r), .OVF(ovf_r)
    );

    logic [2:0] a_f, a_r;
    assign a_f = {a2_f, a1_f, a0_f};
    assign a_r = {a2_r, a1_r, a0_r};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a set of pending indices per mode, plus the offered code.
    bit  m_pend[2][8];
    int  m_code[2];
    int  m_last[2];
    bit  m_v[2];
    bit  m_ovf[2];

    function automatic int count_pending(input int m);
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_pend[m][i]) n++;
        return n;
    endfunction

    function automatic int pick(input int m);
        if (m == 0) begin
            for (int i = 7; i >= 0; i--) if (m_pend[m][i]) return i;
        end else begin
            for (int k = 1; k <= 8; k++) if (m_pend[m][(m_last[m] + k) % 8]) return (m_last[m] + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) m_pend[m][i] = 1'b0;
            m_code[m] = 0;
            m_last[m] = 7;
            m_v[m]    = 1'b0;
            m_ovf[m]  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [7:0] din, input logic r);
        for (int m = 0; m < 2; m++) begin
            int  served;
            bit  accepted;
            accepted = m_v[m] && r;
            served   = accepted ? m_code[m] : -1;
            m_ovf[m] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (i == served) m_pend[m][i] = 1'b0;
                if (din[i] && m_pend[m][i]) m_ovf[m] = 1'b1;
                if (din[i]) m_pend[m][i] = 1'b1;
            end
            if (accepted) m_last[m] = served;
            if (!m_v[m] || accepted) begin
                if (count_pending(m) > 0) begin
                    m_code[m] = pick(m);
                    m_v[m]    = 1'b1;
                end else begin
                    m_v[m] = 1'b0;
                end
            end
        end
    endtask

    // Drive inputs while clk is low, clock once, sample 1 time unit after the edge.
    task automatic step(input logic [7:0] din, input logic r);
        d   = din;
        rdy = r;
        @(posedge clk);
        model_edge(din, r);
        #1;
    endtask

    task automatic check_vs_model(input string tag);
        chk({tag, "_fix_v"},     32'(v_f),     32'(m_v[0]));
        if (m_v[0]) chk({tag, "_fix_a"}, 32'(a_f), 32'(m_code[0]));
        chk({tag, "_fix_multi"}, 32'(multi_f), 32'(count_pending(0) >= 2));
        chk({tag, "_fix_ovf"},   32'(ovf_f),   32'(m_ovf[0]));
        chk({tag, "_rr_v"},      32'(v_r),     32'(m_v[1]));
        if (m_v[1]) chk({tag, "_rr_a"}, 32'(a_r), 32'(m_code[1]));
        chk({tag, "_rr_multi"},  32'(multi_r), 32'(count_pending(1) >= 2));
        chk({tag, "_rr_ovf"},    32'(ovf_r),   32'(m_ovf[1]));
    endtask

    typedef struct {
        logic [7:0] d;
        logic       rdy;
        logic [2:0] a;
        logic       v;
        logic       multi;
        logic       ovf;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // Fixed-priority directed vectors, applied from reset; expected values after each edge.
        tbl[0]  = '{8'h20, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{8'h00, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'h85, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{8'h00, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{8'h04, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{8'h80, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{8'h00, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{8'h00, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{8'h08, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{8'h08, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{8'h00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{8'h00, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{8'h08, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{8'h08, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
        tbl[20] = '{8'h00, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};

        d     = '0;
        rdy   = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_fix_a", 32'(a_f), 32'd0);
        chk("reset_fix_v", 32'(v_f), 32'd0);
        chk("reset_fix_multi", 32'(multi_f), 32'd0);
        chk("reset_fix_ovf", 32'(ovf_f), 32'd0);
        chk("reset_rr_a", 32'(a_r), 32'd0);
        chk("reset_rr_v", 32'(v_r), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].d, tbl[i].rdy);
            chk($sformatf("vec%0d_v", i), 32'(v_f), 32'(tbl[i].v));
            chk($sformatf("vec%0d_a", i), 32'(a_f), 32'(tbl[i].a));
            chk($sformatf("vec%0d_multi", i), 32'(multi_f), 32'(tbl[i].multi));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_f), 32'(tbl[i].ovf));
            @(negedge clk);
        end

        // Asynchronous reset mid-stream with three requests pending.
        step(8'h2A, 1'b0);
        @(negedge clk);
        d   = 8'hFF;
        rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_v", 32'(v_f), 32'd0);
        chk("midrst_a", 32'(a_f), 32'd0);
        chk("midrst_multi", 32'(multi_f), 32'd0);
        chk("midrst_ovf", 32'(ovf_f), 32'd0);
        chk("midrst_rr_v", 32'(v_r), 32'd0);
        d = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(8'h00, 1'b1);
        chk("postrst_v", 32'(v_f), 32'd0);
        chk("postrst_rr_v", 32'(v_r), 32'd0);
        @(negedge clk);

        // Round robin: all eight at once come out ascending from index 0.
        step(8'hFF, 1'b1);
        chk("rr_all_a0", 32'(a_r), 32'd0);
        chk("rr_all_v0", 32'(v_r), 32'd1);
        @(negedge clk);
        for (int k = 1; k < 8; k++) begin
            step(8'h00, 1'b1);
            chk($sformatf("rr_all_a%0d", k), 32'(a_r), 32'(k));
            chk($sformatf("rr_all_v%0d", k), 32'(v_r), 32'd1);
            @(negedge clk);
        end
        step(8'h00, 1'b1);
        chk("rr_all_empty_v", 32'(v_r), 32'd0);
        @(negedge clk);

        // Round robin: after serving 2, pending {1,5} gives 5 then 1.
        step(8'h04, 1'b0);
        chk("rr_wrap_a2", 32'(a_r), 32'd2);
        @(negedge clk);
        step(8'h22, 1'b1);
        chk("rr_wrap_a5", 32'(a_r), 32'd5);
        chk("rr_wrap_multi", 32'(multi_r), 32'd1);
        @(negedge clk);
        step(8'h00, 1'b1);
        chk("rr_wrap_a1", 32'(a_r), 32'd1);
        chk("rr_wrap_v1", 32'(v_r), 32'd1);
        @(negedge clk);
        step(8'h00, 1'b1);
        chk("rr_wrap_empty_v", 32'(v_r), 32'd0);
        @(negedge clk);

        // Randomized traffic on both modes against the reference model.
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] rd;
            logic       rr;
            rd = 8'($urandom) & 8'($urandom) & 8'($urandom);
            rr = ($urandom_range(0, 3) != 0);
            step(rd, rr);
            check_vs_model($sformatf("rnd%0d", n));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
